// File: rtl/demux4_buf_pkg.sv
// Shared constants for the 4-way mux/demux family (used by demux4_buf and mux4).
package demux4_buf_pkg;

  localparam int unsigned NUM_OUT   = 4;
  localparam int unsigned SEL_WIDTH = 2;
  localparam int unsigned OCC_WIDTH = 3;

endpackage

// File: rtl/demux4_fifo.sv
// Per-output FIFO for demux4_buf: DEPTH entries (2 or 4), strict FIFO order.
// Payload storage has no reset; only pointers and occupancy are cleared.
module demux4_fifo
  import demux4_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [OCC_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned          PTR_W    = $clog2(DEPTH);
  localparam logic [OCC_WIDTH-1:0] FULL_CNT = OCC_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [OCC_WIDTH-1:0]  r_count;
  logic                  w_push_en;
  logic                  w_pop_en;

  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;

  // Pointer and occupancy update; rst and flush both discard everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_en) r_wptr <= r_wptr + 1'b1;
      if (w_pop_en)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload write at the tail; suppressed on rst/flush so discarded beats never land.
  always_ff @(posedge clk) begin
    if (w_push_en && !rst && !flush) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;
  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);

endmodule

// File: rtl/demux4_buf.sv
// 1-to-4 buffered demultiplexer: each input beat is routed by in_sel into one of
// four independent FIFOs. in_ready depends only on the selected FIFO's
// registered occupancy, flush and rst -- never on out_ready.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_WIDTH-1:0]  in_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic [OCC_WIDTH-1:0]  occ0,
  output logic [OCC_WIDTH-1:0]  occ1,
  output logic [OCC_WIDTH-1:0]  occ2,
  output logic [OCC_WIDTH-1:0]  occ3
);

  logic [DATA_WIDTH-1:0] w_rdata [NUM_OUT];
  logic [OCC_WIDTH-1:0]  w_count [NUM_OUT];
  logic [NUM_OUT-1:0]    w_full;
  logic [NUM_OUT-1:0]    w_empty;
  logic [NUM_OUT-1:0]    w_push;
  logic [NUM_OUT-1:0]    w_pop;
  logic [NUM_OUT-1:0]    w_out_valid;
  logic                  w_in_ready;

  // full == (occ == DEPTH), so !full is the occ < DEPTH test on the selected buffer.
  assign w_in_ready = !w_full[in_sel] && !flush && !rst;

  // out_valid is forced low while rst is high so no pop can occur during reset.
  assign w_out_valid = ~w_empty & {NUM_OUT{~rst}};

  // Decode in_sel into a one-hot push and gate pops with the per-output handshake.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      w_push[i] = in_valid && w_in_ready && (in_sel == SEL_WIDTH'(i));
      w_pop[i]  = w_out_valid[i] && out_ready[i];
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_fifo
    demux4_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (w_push[k]),
      .pop   (w_pop[k]),
      .wdata (in_data),
      .rdata (w_rdata[k]),
      .count (w_count[k]),
      .full  (w_full[k]),
      .empty (w_empty[k])
    );
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data0 = w_rdata[0];
  assign out_data1 = w_rdata[1];
  assign out_data2 = w_rdata[2];
  assign out_data3 = w_rdata[3];
  assign occ0      = w_count[0];
  assign occ1      = w_count[1];
  assign occ2      = w_count[2];
  assign occ3      = w_count[3];

endmodule

// File: tb/tb_demux4_buf.sv
// Directed self-checking bench for demux4_buf (DATA_WIDTH=64, DEPTH=2).
module tb_demux4_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [63:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [63:0] out_data0, out_data1, out_data2, out_data3;
  logic [2:0]  occ0, occ1, occ2, occ3;

  int unsigned n_checks;
  int unsigned n_errors;

  demux4_buf #(
    .DATA_WIDTH (64),
    .DEPTH      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .occ0      (occ0),
    .occ1      (occ1),
    .occ2      (occ2),
    .occ3      (occ3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
    tick(); tick();
    n_checks++;
    if (out_valid !== 4'b0000) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_checks++;
    if ({occ0, occ1, occ2, occ3} !== 12'h000) begin
      n_errors++; $display("FAIL reset_occ got=%0d,%0d,%0d,%0d exp=0,0,0,0", occ0, occ1, occ2, occ3);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_first_accept got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_beat();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 64'hA5; out_ready = 4'b0000;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b0100) begin n_errors++; $display("FAIL single_out_valid got=%b exp=0100", out_valid); end
    n_checks++;
    if (out_data2 !== 64'hA5) begin n_errors++; $display("FAIL single_data2 got=%h exp=a5", out_data2); end
    n_checks++;
    if (occ2 !== 3'd1) begin n_errors++; $display("FAIL single_occ2 got=%0d exp=1", occ2); end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    n_checks++;
    if (out_valid !== 4'b0000) begin n_errors++; $display("FAIL single_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_fill_backpressure();
    logic [63:0] exp_q [$];
    int unsigned accepts;
    accepts = 0;
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      in_data = 64'(i);
      #1;
      if (in_ready) begin accepts++; exp_q.push_back(in_data); tick(); end
      else break;
    end
    n_checks++;
    if (accepts !== 2) begin n_errors++; $display("FAIL fill_accepts got=%0d exp=2", accepts); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    n_checks++;
    if (occ0 !== 3'd2) begin n_errors++; $display("FAIL fill_occ0 got=%0d exp=2", occ0); end
    // Full buffer with out_ready high: push still refused this cycle.
    in_data = 64'd3;
    out_ready = 4'b0001;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_pop_same_cycle got=%b exp=0", in_ready); end
    n_checks++;
    if (out_data0 !== 64'd1) begin n_errors++; $display("FAIL fill_head1 got=%0d exp=1", out_data0); end
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL fill_next_accept got=%b exp=1", in_ready); end
    n_checks++;
    if (out_data0 !== 64'd2) begin n_errors++; $display("FAIL fill_head2 got=%0d exp=2", out_data0); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_data0 !== 64'd3 || out_valid[0] !== 1'b1) begin
      n_errors++; $display("FAIL fill_head3 got=%0d v=%b exp=3 v=1", out_data0, out_valid[0]);
    end
    tick();
    out_ready = 4'b0000;
    n_checks++;
    if (out_valid[0] !== 1'b0 || occ0 !== 3'd0) begin
      n_errors++; $display("FAIL fill_empty got v=%b occ=%0d exp v=0 occ=0", out_valid[0], occ0);
    end
  endtask

  task automatic test_independence();
    in_valid = 1'b1; in_sel = 2'd1; out_ready = 4'b0000;
    in_data = 64'h11; tick();
    in_data = 64'h12; tick();
    in_sel = 2'd3; in_data = 64'h7;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL indep_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_data3 !== 64'h7 || occ3 !== 3'd1) begin
      n_errors++; $display("FAIL indep_out3 got=%h occ=%0d exp=7 occ=1", out_data3, occ3);
    end
    n_checks++;
    if (occ1 !== 3'd2 || out_data1 !== 64'h11 || out_valid !== 4'b1010) begin
      n_errors++; $display("FAIL indep_out1 got occ=%0d d=%h v=%b exp occ=2 d=11 v=1010", occ1, out_data1, out_valid);
    end
    out_ready = 4'b1010;
    tick();
    n_checks++;
    if (out_data1 !== 64'h12) begin n_errors++; $display("FAIL indep_out1_second got=%h exp=12", out_data1); end
    tick();
    out_ready = 4'b0000;
    n_checks++;
    if (out_valid !== 4'b0000) begin n_errors++; $display("FAIL indep_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 64'd100; out_ready = 4'b0000;
    tick();
    out_ready = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      in_data = 64'(101 + i);
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_data0 !== 64'(100 + i)) begin
        n_errors++; $display("FAIL stream_beat%0d got rdy=%b d=%0d exp rdy=1 d=%0d", i, in_ready, out_data0, 100 + i);
      end
      tick();
      n_checks++;
      if (occ0 !== 3'd1) begin n_errors++; $display("FAIL stream_occ%0d got=%0d exp=1", i, occ0); end
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_data0 !== 64'd110) begin n_errors++; $display("FAIL stream_last got=%0d exp=110", out_data0); end
    tick();
    out_ready = 4'b0000;
    n_checks++;
    if (occ0 !== 3'd0) begin n_errors++; $display("FAIL stream_drain got=%0d exp=0", occ0); end
  endtask

  task automatic test_flush();
    out_ready = 4'b0000; in_valid = 1'b1;
    in_sel = 2'd0; in_data = 64'h1; tick(); in_data = 64'h2; tick();
    in_sel = 2'd1; in_data = 64'h3; tick();
    in_sel = 2'd3; in_data = 64'h4; tick(); in_data = 64'h5; tick();
    in_valid = 1'b0;
    n_checks++;
    if ({occ0, occ1, occ2, occ3} !== {3'd2, 3'd1, 3'd0, 3'd2}) begin
      n_errors++; $display("FAIL flush_setup got=%0d,%0d,%0d,%0d exp=2,1,0,2", occ0, occ1, occ2, occ3);
    end
    flush = 1'b1; in_valid = 1'b1; in_sel = 2'd2; in_data = 64'hDEAD; out_ready = 4'b1111;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    n_checks++;
    if ({occ0, occ1, occ2, occ3} !== 12'h000 || out_valid !== 4'b0000) begin
      n_errors++; $display("FAIL flush_clear got occ=%0d,%0d,%0d,%0d v=%b exp occ=0,0,0,0 v=0000",
                           occ0, occ1, occ2, occ3, out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 4'b0000; in_valid = 1'b1;
    in_sel = 2'd0; in_data = 64'h50; tick();
    in_sel = 2'd3; in_data = 64'h53; tick(); in_data = 64'h54; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_during got v=%b rdy=%b exp v=0000 rdy=0", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if ({occ0, occ1, occ2, occ3} !== 12'h000 || out_valid !== 4'b0000) begin
      n_errors++; $display("FAIL rst_mid_clear got occ=%0d,%0d,%0d,%0d v=%b exp 0 v=0000",
                           occ0, occ1, occ2, occ3, out_valid);
    end
    rst = 1'b0; in_valid = 1'b1; in_sel = 2'd3; in_data = 64'h99;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_accept got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 4'b1000 || out_data3 !== 64'h99 || occ3 !== 3'd1) begin
      n_errors++; $display("FAIL rst_mid_fresh got v=%b d=%h occ=%0d exp v=1000 d=99 occ=1", out_valid, out_data3, occ3);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_single_beat();
    test_fill_backpressure();
    test_independence();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
